dot_matrix_scanner: RTL and testbench

Parametrised multiplexed LED dot-matrix driver: a COLS x ROWS frame buffer written from system logic, scanned one column at a time onto one-hot column sinks and row sources. It adds the following:
- a single clock with an internal prescaler in place of separate logic and column clocks;
- per-slot blanking to suppress ghosting;
- global PWM brightness;
- optional double-buffered frames with a tear-free swap handshake.

It sits between display-writer logic and the matrix pins.

---
 rtl/dot_matrix_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_dot_matrix_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner
//   Multiplexed LED dot-matrix driver. A COLS x ROWS frame buffer is written
//   column-word at a time by system logic and scanned one column per slot
//   onto one-hot column sinks and row sources. One clock drives everything;
//   an internal prescaler derives the scan tick. Each slot opens with BLANK
//   dark ticks (anti-ghosting), followed by a PWM phase of 2^BR_W ticks of
//   which `brightness` are lit.
//
//   Build option: define DOT_DOUBLE_BUFFER_EN for front/back frame buffers
//   with a tear-free swap at frame boundaries. Without it there is a single
//   buffer, swap_req is ignored and swap_done stays 0.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   enable       scan enable; low freezes the scan and darkens outputs
//   wr_en        write strobe for one column word
//   wr_addr      column written (values >= COLS ignored)
//   wr_data      row pattern, bit i lights row i
//   brightness   lit ticks per slot (0 = dark)
//   swap_req     request buffer swap (double-buffer build only)
//   swap_done    one-clk pulse when a swap takes effect
//   frame_start  one-clk pulse on entry to the column 0 slot
//   col_out      one-hot column sink, bit COLS-1 selects column 0
//   row_out      row drive for the selected column
module dot_matrix_scanner #(
  parameter int COLS     = 5,
  parameter int ROWS     = 7,
  parameter int PRESCALE = 4,
  parameter int BLANK    = 2,
  parameter int BR_W     = 3,
  parameter int AW       = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [ROWS-1:0] wr_data,
  input  logic [BR_W-1:0] brightness,
  input  logic            swap_req,
  output logic            swap_done,
  output logic            frame_start,
  output logic [COLS-1:0] col_out,
  output logic [ROWS-1:0] row_out
);

  localparam int SLOT = BLANK + (1 << BR_W);
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW   = $clog2(SLOT);
  localparam int CMPW = (SW > BR_W) ? SW : BR_W;

  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]   SLOT_LAST  = SW'(SLOT - 1);
  localparam logic [SW-1:0]   BLANK_S    = SW'(BLANK);
  localparam logic [AW-1:0]   COL_LAST   = AW'(COLS - 1);
  localparam logic [COLS-1:0] COL0_SEL   = {1'b1, {(COLS-1){1'b0}}};

  logic [PW-1:0]   presc, presc_nxt;
  logic [SW-1:0]   slot_cnt, slot_nxt;
  logic [AW-1:0]   col, col_nxt;
  logic [ROWS-1:0] lat_word, lat_word_nxt;
  logic [BR_W-1:0] lat_bright, lat_bright_nxt;
  logic            tick;
  logic            slot_entry;
  logic            frame_entry;
  logic            swap_now;
  logic [ROWS-1:0] front_word;
  logic            wr_ok;
  logic [CMPW-1:0] phase;
  logic            lit;
  logic [COLS-1:0] col_out_nxt;
  logic [ROWS-1:0] row_out_nxt;

  assign wr_ok       = wr_en && ({1'b0, wr_addr} < (AW+1)'(COLS));
  assign slot_entry  = tick && (slot_cnt == SLOT_LAST);
  assign frame_entry = slot_entry && (col == COL_LAST);

`ifdef DOT_DOUBLE_BUFFER_EN
  logic [ROWS-1:0] fb0 [COLS];
  logic [ROWS-1:0] fb1 [COLS];
  logic            front, front_nxt;
  logic            pending, pending_nxt;

  // A request arriving on the swap edge itself stays pending for the next frame.
  assign swap_now    = frame_entry && pending;
  assign front_nxt   = front ^ swap_now;
  assign pending_nxt = swap_req || (pending && !swap_now);
  // Column 0 of a swapped frame must already come from the new front buffer.
  assign front_word  = front_nxt ? fb1[col_nxt] : fb0[col_nxt];

  // Frame buffers, front select and pending swap; writes go to the back buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) begin
        fb0[i] <= {ROWS{1'b0}};
        fb1[i] <= {ROWS{1'b0}};
      end
      front   <= 1'b0;
      pending <= 1'b0;
    end else begin
      front   <= front_nxt;
      pending <= pending_nxt;
      if (wr_ok) begin
        if (front) fb0[wr_addr] <= wr_data;
        else       fb1[wr_addr] <= wr_data;
      end
    end
  end
`else
  logic [ROWS-1:0] fb0 [COLS];
  logic            unused_swap_req;

  assign unused_swap_req = swap_req;
  assign swap_now        = 1'b0;
  assign front_word      = fb0[col_nxt];

  // Single frame buffer written directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) fb0[i] <= {ROWS{1'b0}};
    end else if (wr_ok) begin
      fb0[wr_addr] <= wr_data;
    end
  end
`endif

  // Scan state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= {PW{1'b0}};
      slot_cnt    <= SLOT_LAST;
      col         <= COL_LAST;
      lat_word    <= {ROWS{1'b0}};
      lat_bright  <= {BR_W{1'b0}};
      col_out     <= {COLS{1'b0}};
      row_out     <= {ROWS{1'b0}};
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      presc       <= presc_nxt;
      slot_cnt    <= slot_nxt;
      col         <= col_nxt;
      lat_word    <= lat_word_nxt;
      lat_bright  <= lat_bright_nxt;
      col_out     <= col_out_nxt;
      row_out     <= row_out_nxt;
      frame_start <= frame_entry;
      swap_done   <= swap_now;
    end
  end

  // Next-state: prescaler, slot tick counter and column index.
  always_comb begin
    presc_nxt = presc;
    slot_nxt  = slot_cnt;
    col_nxt   = col;
    tick      = 1'b0;
    if (enable) begin
      if (presc == PRESC_LAST) begin
        presc_nxt = {PW{1'b0}};
        tick      = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1'b1);
      end
    end else begin
      presc_nxt = presc;
    end
    if (tick) begin
      if (slot_cnt == SLOT_LAST) begin
        slot_nxt = {SW{1'b0}};
        col_nxt  = (col == COL_LAST) ? {AW{1'b0}} : col + AW'(1'b1);
      end else begin
        slot_nxt = slot_cnt + SW'(1'b1);
      end
    end else begin
      slot_nxt = slot_cnt;
    end
  end

  // Outputs: latch column data at slot entry, then blank / PWM from the new counters.
  always_comb begin
    lat_word_nxt   = lat_word;
    lat_bright_nxt = lat_bright;
    if (slot_entry) begin
      lat_word_nxt   = front_word;
      lat_bright_nxt = brightness;
    end else begin
      lat_word_nxt   = lat_word;
      lat_bright_nxt = lat_bright;
    end
    // phase only matters once past the blanking ticks, so wrap below BLANK is harmless
    phase = CMPW'(slot_nxt - BLANK_S);
    lit   = enable && (slot_nxt >= BLANK_S) && (phase < CMPW'(lat_bright_nxt));
    if (lit) begin
      col_out_nxt = COL0_SEL >> col_nxt;
      row_out_nxt = lat_word_nxt;
    end else begin
      col_out_nxt = {COLS{1'b0}};
      row_out_nxt = {ROWS{1'b0}};
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner (default parameters).
// A cycle model derived from elapsed enabled clocks pushes the expected
// outputs of each edge into a scoreboard queue; they are popped and compared
// after the edge. Directed checks cover timing figures, dark frames,
// out-of-range writes, enable drop, swap and asynchronous reset.
module tb_dot_matrix_scanner;
  localparam int COLS     = 5;
  localparam int ROWS     = 7;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 2;
  localparam int BR_W     = 3;
  localparam int AW       = 3;
  localparam int SLOT     = BLANK + (1 << BR_W);
  localparam int FRAME    = COLS * SLOT * PRESCALE;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [ROWS-1:0] wr_data;
  logic [BR_W-1:0] brightness;
  logic            swap_req;
  logic            swap_done;
  logic            frame_start;
  logic [COLS-1:0] col_out;
  logic [ROWS-1:0] row_out;

  dot_matrix_scanner dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .brightness(brightness),
    .swap_req(swap_req), .swap_done(swap_done), .frame_start(frame_start),
    .col_out(col_out), .row_out(row_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int gcyc  = 0;
  logic [13:0] exp_q[$];

  // model state
  int              e_cnt;
  logic [ROWS-1:0] m_buf0 [COLS];
  logic [ROWS-1:0] m_buf1 [COLS];
  logic            m_front;
  logic            m_pend;
  logic [ROWS-1:0] m_word;
  logic [BR_W-1:0] m_bright;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    e_cnt = 0;
    for (int i = 0; i < COLS; i++) begin
      m_buf0[i] = '0;
      m_buf1[i] = '0;
    end
    m_front  = 1'b0;
    m_pend   = 1'b0;
    m_word   = '0;
    m_bright = '0;
  endtask

  // Predict the outputs produced by the coming edge from the current inputs.
  task automatic model_edge();
    int t, g, s, c;
    logic tk, entry, fs, sw, nf, lit;
    logic [COLS-1:0] one;
    logic [COLS-1:0] ce;
    logic [ROWS-1:0] re;
    one = 1;
    tk  = 1'b0;
    if (enable) begin
      e_cnt++;
      tk = ((e_cnt % PRESCALE) == 0);
    end
    t = e_cnt / PRESCALE;
    if (t == 0) begin
      s = SLOT - 1;
      c = COLS - 1;
    end else begin
      g = t - 1;
      s = g % SLOT;
      c = (g / SLOT) % COLS;
    end
    entry = tk && (s == 0);
    fs    = entry && (c == 0);
`ifdef DOT_DOUBLE_BUFFER_EN
    sw = fs && m_pend;
`else
    sw = 1'b0;
`endif
    nf = m_front ^ sw;
    if (entry) begin
      m_word   = nf ? m_buf1[c] : m_buf0[c];
      m_bright = brightness;
    end
    if (wr_en && (wr_addr < COLS)) begin
`ifdef DOT_DOUBLE_BUFFER_EN
      if (m_front) m_buf0[wr_addr] = wr_data;
      else         m_buf1[wr_addr] = wr_data;
`else
      m_buf0[wr_addr] = wr_data;
`endif
    end
`ifdef DOT_DOUBLE_BUFFER_EN
    m_pend = swap_req || (m_pend && !sw);
`endif
    m_front = nf;
    lit = enable && (s >= BLANK) && ((s - BLANK) < int'(m_bright));
    ce  = lit ? (one << (COLS - 1 - c)) : '0;
    re  = lit ? m_word : '0;
    exp_q.push_back({sw, fs, ce, re});
  endtask

  task automatic step();
    logic [13:0] e;
    model_edge();
    @(posedge clk);
    #1;
    gcyc++;
    e = exp_q.pop_front();
    chk("scan", {18'd0, swap_done, frame_start, col_out, row_out}, {18'd0, e});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fs(output int at);
    at = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_start) begin
        at = gcyc;
        break;
      end
    end
    if (at < 0) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_lit();
    for (int i = 0; i < 3 * SLOT * PRESCALE; i++) begin
      if (col_out != '0) break;
      step();
    end
  endtask

  task automatic count_frame(output int nzc, output int nzr, output int c2,
                             output int sd, output int f7);
    nzc = 0; nzr = 0; c2 = 0; sd = 0; f7 = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (col_out != '0) nzc++;
      if (row_out != '0) nzr++;
      if (col_out == 5'b00100 && row_out == 7'b1010101) c2++;
      if (swap_done) sd++;
      if (col_out != '0 && row_out == 7'h7F) f7++;
    end
  endtask

  initial begin
    int fs1, fs2, lit_at;
    int nzc, nzr, c2, sd, f7;
    logic [COLS-1:0] lit_val;
    logic [COLS-1:0] saved_col;

    reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    brightness = '0; swap_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_col_out", col_out, 5'b0);
    chk("rst_row_out", row_out, 7'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_swap_done", swap_done, 1'b0);

    // first frame with all-zero buffers: columns still lit, rows dark
    reset = 1'b0; enable = 1'b1; brightness = 3'd7;
    fs1 = 0; lit_at = 0; lit_val = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (frame_start && fs1 == 0) fs1 = gcyc;
      if (col_out != '0 && lit_at == 0) begin
        lit_at  = gcyc;
        lit_val = col_out;
      end
    end
    chk("first_fs_clk", fs1, 32'd4);
    chk("first_lit_clk", lit_at, 32'd12);
    chk("first_lit_col", lit_val, 5'b10000);

    // column 2 pattern at full brightness
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 7'b1010101;
    step();
    wr_en = 1'b0;
`ifdef DOT_DOUBLE_BUFFER_EN
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
`endif
    wait_fs(fs2);
    chk("frame_period", fs2 - fs1, FRAME);
    count_frame(nzc, nzr, c2, sd, f7);
    chk("c2_lit_clks", c2, 32'd28);
    chk("row_lit_clks", nzr, 32'd28);
    chk("col_lit_clks", nzc, 32'd140);

    // brightness 0 plus an out-of-range write
    brightness = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 7'h7F;
    step();
    wr_en = 1'b0;
    wait_fs(fs2);
    count_frame(nzc, nzr, c2, sd, f7);
    chk("dark_col_clks", nzc, 32'd0);
    chk("dark_row_clks", nzr, 32'd0);
    brightness = 3'd7;
    wait_fs(fs2);
    count_frame(nzc, nzr, c2, sd, f7);
    chk("oor_row_clks", nzr, 32'd28);
    chk("oor_c2_clks", c2, 32'd28);

    // drop enable on a lit edge, then resume
    wait_lit();
    chk("pre_drop_lit", col_out != '0, 1'b1);
    saved_col = col_out;
    enable = 1'b0;
    step();
    chk("drop_col", col_out, 5'b0);
    chk("drop_row", row_out, 7'b0);
    run(6);
    enable = 1'b1;
    step();
    chk("resume_col", col_out, saved_col);
    run(40);

`ifdef DOT_DOUBLE_BUFFER_EN
    for (int a = 0; a < COLS; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 7'h7F;
      step();
    end
    wr_en = 1'b0;
    wait_fs(fs2);
    run(50);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    wait_fs(fs2);
    chk("swap_with_fs", swap_done, 1'b1);
    count_frame(nzc, nzr, c2, sd, f7);
    chk("new_frame_7f", f7, 32'd140);
    chk("no_extra_swap", sd, 32'd0);
`endif

    // asynchronous reset during a lit tick (with a swap pending when built)
    wait_lit();
`ifdef DOT_DOUBLE_BUFFER_EN
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
`endif
    chk("pre_rst_lit", col_out != '0, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_async_col", col_out, 5'b0);
    chk("rst_async_row", row_out, 7'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    wait_fs(fs2);
    chk("post_rst_no_swap", swap_done, 1'b0);
    count_frame(nzc, nzr, c2, sd, f7);
    chk("post_rst_swaps", sd, 32'd0);
    chk("post_rst_rows", nzr, 32'd0);
    chk("post_rst_cols", nzc, 32'd140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
